// File: rtl/multi32_pkg.sv
// Shared types and widths for the multi32 arbiter slice.
package multi32_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/multi32_arbiter_if.sv
// Requester-side bundle: per-requester request/response handshakes plus status.
interface multi32_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import multi32_pkg::*;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_a;
  logic [NUM_REQ*OP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [PROD_W-1:0]       rsp_prod;
  logic                    busy;
  logic [31:0]             op_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_prod, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_prod, busy, op_count
  );

endinterface

// File: rtl/multi32.sv
// 32x32 -> 64 unsigned combinational multiplier, treated as a multicycle path.
module multi32
  import multi32_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product
);

  assign product = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_valid_o
);

  function automatic logic [IDX_W-1:0] rot_src(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // rot[k] is the request k positions after the pointer.
  logic [NUM_REQ-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot[gi] = req_i[rot_src(ptr_i, gi)];
    end
  endgenerate

  always_comb begin
    int off;
    off = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    grant_o = rot_src(ptr_i, off);
  end

  assign any_valid_o = |rot;

endmodule

// File: rtl/multi32_arbiter.sv
// Round-robin share of one multi32 between NUM_REQ requesters with a fixed compute window.
module multi32_arbiter
  import multi32_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MUL_CYCLES = 2,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  multi32_arbiter_if.slave    bus
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [OP_W-1:0]     op_a_q, op_a_d;
  logic [OP_W-1:0]     op_b_q, op_b_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         op_count_q, op_count_d;

  logic [IDX_W-1:0]    grant;
  logic                any_valid;
  logic [PROD_W-1:0]   product;
  logic [NUM_REQ-1:0]  req_ready;
  logic [NUM_REQ-1:0]  rsp_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  // Multiplier sees only the held operand registers, so its inputs are stable for the whole window.
  multi32 u_mul (
    .a       (op_a_q),
    .b       (op_b_q),
    .product (product)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    op_count_d = op_count_q;
    req_ready  = '0;
    rsp_valid  = '0;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          // Gated by rst_n so no ready leaks out while reset is held.
          req_ready[grant] = rst_n;
          op_a_d  = bus.req_a[int'(grant)*OP_W +: OP_W];
          op_b_d  = bus.req_b[int'(grant)*OP_W +: OP_W];
          owner_d = grant;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          prod_d  = product;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(wrap_inc(int'(owner_q), NUM_REQ));
          if (op_count_q != '1) op_count_d = op_count_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_prod  = prod_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = op_count_q;

endmodule

// File: doc/multi32_arbiter.md
Name: multi32_arbiter

Overview:
- Shares one multi32 (32x32 -> 64 unsigned multiplier, combinational) between NUM_REQ requesters.
- Round-robin arbitration, registered operands, fixed multicycle compute window, registered result.
- Per-requester valid/ready handshake on both request and response.
- Sits between the requester blocks and the single multiplier instance, which is treated as a multicycle path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_CYCLES, 2, cycles operands are held stable before the product is captured (1..15).
- IDX_W, $clog2(NUM_REQ), requester index width (derived; not to be overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted, one-hot or zero.
- req_a  in  NUM_REQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B; same packing as req_a.
- rsp_valid  out  NUM_REQ  product valid for the owning requester, one-hot or zero.
- rsp_ready  in  NUM_REQ  response consumed.
- rsp_prod  out  64  product; shared bus, meaningful only where rsp_valid is set.
- busy  out  1  high whenever state != IDLE.
- op_count  out  32  completed-operation counter; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, owner=0, operand regs=0, rsp_prod=0, cnt=0, op_count=0; all outputs low.
- States: IDLE, CALC, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - req_ready[grant]=1, driven combinationally in the same cycle; all other req_ready bits stay 0.
  - On that edge: capture req_a/req_b slices of grant into op_a/op_b; owner<=grant; cnt<=MUL_CYCLES-1; ->CALC.
  - No valid requesters: stay in IDLE, all req_ready=0.
- CALC:
  - multi32 is driven only from op_a/op_b.
  - If cnt==0: rsp_prod<=product; ->RESP. Otherwise cnt<=cnt-1.
  - req_ready all 0; req_valid changes are ignored.
- RESP:
  - rsp_valid[owner]=1.
  - On rsp_ready[owner]: ->IDLE; rr_ptr<=(owner+1) mod NUM_REQ; op_count<=op_count+1 unless already saturated.
  - rsp_ready bits of non-owners are ignored.
  - rsp_prod holds stable until the handshake completes.
- Latency: rsp_valid rises exactly MUL_CYCLES clock edges after the accept edge.
- Minimum issue interval is MUL_CYCLES+2 cycles, because a new accept is never made in the cycle of a response handshake.
- Requester obligation: hold req_valid and operands stable until req_ready. The block does not check this.
- Fairness: a requester holding req_valid is granted within NUM_REQ operations.
- Arithmetic: unsigned 32x32 -> full 64-bit product, no truncation.
- Reset mid-operation: the in-flight op is discarded, no rsp_valid is produced, op_count is unchanged by the dropped op.
- Invariant: at most one bit of req_ready, and at most one bit of rsp_valid, is high in any cycle.

Decomposition:
- Package multi32_pkg:
  - state enum {IDLE, CALC, RESP}.
  - localparams OP_W=32, PROD_W=64.
- Sub-module rr_pick (combinational round-robin priority pick: in = req vector + ptr; out = grant index + any_valid).
- Instantiate multi32 once, ports (a, b, product).

Test Plan:
- Single op: requester 0 sends a=300015900, b=199004 -> req_ready[0] in the same cycle; rsp_valid[0] rises after MUL_CYCLES edges; rsp_prod=59704364163600; op_count=1.
- Max operands: a=b=0xFFFFFFFF -> rsp_prod=0xFFFFFFFE00000001. Then a=0, b=0xFFFFFFFF -> rsp_prod=0.
- All 4 requesters hold valid continuously -> grant order 0,1,2,3,0; each rsp_valid appears only on its owner; issue interval = MUL_CYCLES+2.
- Response backpressure: hold rsp_ready[owner]=0 for 10 cycles and pulse non-owner rsp_ready bits -> rsp_valid and rsp_prod stable; busy=1; no new req_ready.
- Reset asserted mid-CALC -> all outputs 0 immediately (asynchronous); after release, first grant goes to the lowest valid index.
- op_count saturation: force op_count to 0xFFFFFFFE, complete 3 ops -> op_count stays 0xFFFFFFFF.
